core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue core: fetches via imem handshake, holds IR/PC, times
//  the combinational exu (alu_out, B_result), drives dmem for load/store, issues one regfile write
//  per instruction and computes next PC. Sits between imem/dmem ports and the decoder/regfile/exu.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  ACK_TIMEOUT  255            max wait cycles for imem_ack/dmem_ack; 0 disables timeout
// PORTS
//  clk         in   1   core clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  imem_req    out  1   fetch request, held until imem_ack
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   32  instruction word
//  ir          out  32  instruction register to decoder
//  pc          out  32  current PC to exu
//  alu_out     in   32  exu result
//  b_result    in   1   exu branch decision (1 = taken)
//  dmem_req    out  1   data request, held until dmem_ack
//  dmem_we     out  1   1 = store, 0 = load
//  dmem_addr   out  32  = latched alu result
//  dmem_size   out  3   = ir funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw)
//  dmem_ack    in   1   data complete; load data valid this cycle
//  rf_we       out  1   regfile write strobe, one cycle, never when rd = x0
//  wb_sel      out  2   00 alu_q, 01 load data, 10 pc+4
//  halt        out  1   sticky trap indicator
//  trap_cause  out  2   00 none, 01 illegal opcode, 10 misaligned target, 11 bus timeout
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, pc=RESET_PC, ir=0, alu_q=0, all strobes 0,
//   halt=0, trap_cause=00, timeout counter 0. Reset mid-handshake abandons it; no completion.
//  States: IDLE->FETCH (unconditional). FETCH: imem_req=1; on imem_ack latch ir -> DECODE.
//   DECODE (1 cycle): opcode legal -> EXEC, else TRAP/01. EXEC (1 cycle): latch alu_out->alu_q,
//   b_result->br_q; load/store -> MEM; branch -> FETCH; others -> WB.
//   MEM: dmem_req=1; on dmem_ack: store -> FETCH, load -> WB (load data latched by datapath).
//   WB (1 cycle): rf_we=1 (if rd!=0), wb_sel per class -> FETCH. TRAP: terminal until reset;
//   all req/we strobes 0, pc frozen.
//  Next PC, applied on entry to FETCH: branch & br_q -> alu_q; jal/jalr -> alu_q; else pc+4
//   (32-bit wrap, 32'hFFFF_FFFC + 4 = 0). Redirect target[1:0]!=0 -> TRAP/10, pc unchanged.
//  wb_sel: R/I-arith/lui/auipc 00; load 01; jal/jalr 10.
//  Handshake: req, addr, we, size stable from assertion until ack sampled; ack same cycle as
//   req assertion (zero-wait) legal; ack while req=0 ignored; req drops the cycle after ack.
//  Timeout: counter clears on req assertion, increments each waiting cycle; reaching
//   ACK_TIMEOUT without ack -> TRAP/11, req deasserted. Ack on the limit cycle wins.
//  Latency (zero-wait memory): branch/jump-none 4 cycles, ALU/U/J 5, store 5, load 6.
// STRUCTURE
//  State encoding and trap_cause codes added to define.v beside existing opcode/funct3 macros.
//  One sub-module: seq_ack_timer (load/clear/expire counter, shared by FETCH and MEM waits).
// TESTING
//  1 Reset release, imem_ack tied 1, ir=addi x1,x0,5 -> req at cycle 1, rf_we pulse, wb_sel 00,
//    pc 0->4 after 5 cycles.
//  2 beq taken, alu_out=32'h40 in EXEC, b_result=1 -> no rf_we, next imem_addr=32'h40; b_result=0
//    -> 32'h4.
//  3 lw with dmem_ack delayed 3 cycles -> dmem_req/addr/size stable 4 cycles, then rf_we, wb_sel 01.
//  4 jal, alu_out=32'h102 -> halt=1, trap_cause=10, pc unchanged, no further imem_req.
//  5 opcode 7'h7F -> TRAP/01; ACK_TIMEOUT=4, imem_ack never -> halt, trap_cause=11, req low.
//  6 rst_n low mid-MEM wait -> dmem_req 0 immediately, pc=RESET_PC, refetch after release.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, trap causes,
// writeback selects and the RV32I opcodes the sequencer recognises.
package core_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        TC_NONE     = 2'b00,
        TC_ILLEGAL  = 2'b01,
        TC_MISALIGN = 2'b10,
        TC_TIMEOUT  = 2'b11
    } trap_cause_e;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_ack_timer.sv
// Handshake wait counter shared by the fetch and data waits. Counts while
// run is high, clears otherwise; expire flags the last allowed wait cycle.
module seq_ack_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);
    localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= run ? count + ONE : '0;
    end

    // LIMIT of zero disables the timeout; the counter then just wraps.
    assign expire = (LIMIT != 0) && run && (count == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch handshake, IR/PC ownership,
// exu timing, load/store handshake, regfile write strobe and next-PC.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic        b_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [2:0]  dmem_size,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic [1:0]  trap_cause
);
    seq_state_e  state;
    trap_cause_e cause;
    logic [31:0] alu_q, pc_plus4, next_pc;
    logic        is_load, is_store, is_branch, is_jump, rd_nz;
    logic        waiting, ack_now, expire, redirect, fetch_go, trap_now;

    assign imem_addr = pc;
    assign dmem_addr = alu_q;
    assign dmem_size = ir[14:12];
    assign pc_plus4  = pc + 32'd4;

    assign is_load   = (ir[6:0] == OP_LOAD);
    assign is_store  = (ir[6:0] == OP_STORE);
    assign is_branch = (ir[6:0] == OP_BRANCH);
    assign is_jump   = (ir[6:0] == OP_JAL) || (ir[6:0] == OP_JALR);
    assign rd_nz     = (ir[11:7] != 5'd0);

    assign waiting = (state == S_FETCH) || (state == S_MEM);
    assign ack_now = ((state == S_FETCH) && imem_ack) || ((state == S_MEM) && dmem_ack);

    seq_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (waiting && !ack_now),
        .expire (expire)
    );

    // Branches leave EXEC straight for FETCH, so the live exu outputs are used
    // there; jumps redirect from WB using the value latched in EXEC.
    always_comb begin
        redirect = 1'b0;
        next_pc  = pc_plus4;
        if (state == S_EXEC && is_branch && b_result) begin
            redirect = 1'b1;
            next_pc  = alu_out;
        end else if (state == S_WB && is_jump) begin
            redirect = 1'b1;
            next_pc  = alu_q;
        end
        fetch_go = ((state == S_EXEC) && is_branch) ||
                   ((state == S_MEM) && dmem_ack && is_store) ||
                   (state == S_WB);
        trap_now = 1'b0;
        cause    = TC_NONE;
        if (state == S_DECODE && !op_legal(ir[6:0])) begin
            trap_now = 1'b1;
            cause    = TC_ILLEGAL;
        end else if (expire) begin
            trap_now = 1'b1;
            cause    = TC_TIMEOUT;
        end else if (fetch_go && redirect && next_pc[1:0] != 2'b00) begin
            trap_now = 1'b1;
            cause    = TC_MISALIGN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            alu_q      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            wb_sel     <= WB_ALU;
            halt       <= 1'b0;
            trap_cause <= TC_NONE;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: if (imem_ack) begin
                    ir       <= imem_rdata;
                    imem_req <= 1'b0;
                    state    <= S_DECODE;
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    alu_q <= alu_out;
                    if (is_load || is_store) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
                    end else if (!is_branch) begin
                        state  <= S_WB;
                        rf_we  <= rd_nz;
                        wb_sel <= is_jump ? WB_PC4 : WB_ALU;
                    end
                end
                S_MEM: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    if (is_load) begin
                        state  <= S_WB;
                        rf_we  <= rd_nz;
                        wb_sel <= WB_LOAD;
                    end
                end
                default: ;
            endcase
            if (fetch_go && !trap_now) begin
                pc       <= next_pc;
                state    <= S_FETCH;
                imem_req <= 1'b1;
            end
            if (trap_now) begin
                state      <= S_TRAP;
                halt       <= 1'b1;
                trap_cause <= cause;
                imem_req   <= 1'b0;
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
                rf_we      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: a small imem/dmem responder plus queues of
// expected fetch addresses, data requests and writeback selects.
module tb_core_seq_ctrl;
    localparam int unsigned TMO = 4;

    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_NOP  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_LW   = 32'h0000_2103; // lw x2,0(x0)
    localparam logic [31:0] I_SW   = 32'h0000_2023;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF; // jal x1
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
    } dreq_t;

    logic        clk, rst_n;
    logic        imem_req, imem_ack, b_result, dmem_req, dmem_we, dmem_ack;
    logic        rf_we, halt;
    logic [31:0] imem_addr, imem_rdata, ir, pc, alu_out, dmem_addr;
    logic [2:0]  dmem_size;
    logic [1:0]  wb_sel, trap_cause;

    core_seq_ctrl #(.RESET_PC(32'h0), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .alu_out(alu_out), .b_result(b_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_size(dmem_size),
        .dmem_ack(dmem_ack), .rf_we(rf_we), .wb_sel(wb_sel), .halt(halt), .trap_cause(trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem_arr [0:63];
    logic [31:0] exp_fetch [$];
    logic [1:0]  exp_wb [$];
    dreq_t       exp_dmem [$];
    int n_cmp = 0, n_err = 0;
    int ireq_cycles, dreq_cycles, rfwe_cnt, dcnt, dmem_delay;
    bit imem_auto;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        if (imem_req) ireq_cycles++;
        if (dmem_req) begin
            dreq_cycles++;
            check("dmem_pending", 32'(exp_dmem.size() != 0), 32'd1);
            if (exp_dmem.size() != 0) begin
                check("dmem_addr", dmem_addr, exp_dmem[0].addr);
                check("dmem_we", 32'(dmem_we), 32'(exp_dmem[0].we));
                check("dmem_size", 32'(dmem_size), 32'(exp_dmem[0].size));
            end
        end
        if (rf_we) begin
            rfwe_cnt++;
            check("rf_we_pending", 32'(exp_wb.size() != 0), 32'd1);
            if (exp_wb.size() != 0) check("wb_sel", 32'(wb_sel), 32'(exp_wb.pop_front()));
        end
    endtask

    task automatic drive();
        imem_ack = 1'b0;
        if (imem_req && imem_auto) begin
            check("fetch_pending", 32'(exp_fetch.size() != 0), 32'd1);
            if (exp_fetch.size() != 0) check("fetch_addr", imem_addr, exp_fetch.pop_front());
            imem_ack   = 1'b1;
            imem_rdata = imem_arr[imem_addr[7:2]];
        end
        dmem_ack = 1'b0;
        if (dmem_req) begin
            if (dcnt == dmem_delay) begin
                dmem_ack = 1'b1;
                dcnt     = 0;
                if (exp_dmem.size() != 0) void'(exp_dmem.pop_front());
            end else dcnt++;
        end else dcnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 64; i++) imem_arr[i] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_fetch.delete(); exp_wb.delete(); exp_dmem.delete();
        imem_auto = 1'b1; dmem_delay = 0; alu_out = '0; b_result = 1'b0;
        run(2);
        ireq_cycles = 0; dreq_cycles = 0; rfwe_cnt = 0;
    endtask

    task automatic drained(input string tag);
        check({tag, "_fetchq"}, 32'(exp_fetch.size()), 32'd0);
        check({tag, "_wbq"}, 32'(exp_wb.size()), 32'd0);
        check({tag, "_dmemq"}, 32'(exp_dmem.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        dcnt = 0; ireq_cycles = 0; dreq_cycles = 0; rfwe_cnt = 0;

        // 1: reset state, then addi / nop with zero-wait fetch
        do_reset();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        fill(I_NOP); imem_arr[0] = I_ADDI; alu_out = 32'd5;
        exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
        exp_wb.push_back(2'b00);
        rst_n = 1'b1;
        run(1);
        check("t1_req_c1", 32'(imem_req), 32'd1);
        run(3);
        check("t1_rf_we_c4", 32'(rf_we), 32'd1);
        check("t1_pc_c4", pc, 32'h0);
        run(1);
        check("t1_pc_c5", pc, 32'h4);
        run(4);
        check("t1_rfwe_cnt", 32'(rfwe_cnt), 32'd1);
        drained("t1");

        // 2: beq taken to 0x40, then not taken
        do_reset();
        fill(I_BEQ); alu_out = 32'h40; b_result = 1'b1;
        exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h40); exp_fetch.push_back(32'h40);
        rst_n = 1'b1;
        run(7);
        check("t2a_pc", pc, 32'h40);
        check("t2a_rfwe_cnt", 32'(rfwe_cnt), 32'd0);
        drained("t2a");
        do_reset();
        fill(I_BEQ); alu_out = 32'h40; b_result = 1'b0;
        exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
        rst_n = 1'b1;
        run(7);
        check("t2b_pc", pc, 32'h8);
        drained("t2b");

        // 3: lw then sw, dmem_ack 3 cycles late (lands on the timeout limit cycle)
        do_reset();
        fill(I_NOP); imem_arr[0] = I_LW; imem_arr[1] = I_SW;
        alu_out = 32'h100; dmem_delay = 3;
        exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
        exp_dmem.push_back('{addr: 32'h100, we: 1'b0, size: 3'b010});
        exp_dmem.push_back('{addr: 32'h100, we: 1'b1, size: 3'b010});
        exp_wb.push_back(2'b01);
        rst_n = 1'b1;
        run(8);
        check("t3_ld_rf_we", 32'(rf_we), 32'd1);
        run(8);
        check("t3_dreq_cycles", 32'(dreq_cycles), 32'd8);
        check("t3_halt", 32'(halt), 32'd0);
        drained("t3");

        // 4: jal to misaligned target
        do_reset();
        fill(I_JAL); alu_out = 32'h102;
        exp_fetch.push_back(32'h0); exp_wb.push_back(2'b10);
        rst_n = 1'b1;
        run(5);
        check("t4_halt", 32'(halt), 32'd1);
        check("t4_cause", 32'(trap_cause), 32'd2);
        check("t4_pc", pc, 32'h0);
        run(5);
        check("t4_ireq_cycles", 32'(ireq_cycles), 32'd1);
        check("t4_imem_req", 32'(imem_req), 32'd0);
        drained("t4");

        // 5a: illegal opcode
        do_reset();
        fill(I_BAD);
        exp_fetch.push_back(32'h0);
        rst_n = 1'b1;
        run(3);
        check("t5a_halt", 32'(halt), 32'd1);
        check("t5a_cause", 32'(trap_cause), 32'd1);
        run(2);
        check("t5a_rfwe_cnt", 32'(rfwe_cnt), 32'd0);
        drained("t5a");

        // 5b: imem never acks
        do_reset();
        imem_auto = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !halt; i++) tick();
        check("t5b_halt", 32'(halt), 32'd1);
        check("t5b_cause", 32'(trap_cause), 32'd3);
        check("t5b_imem_req", 32'(imem_req), 32'd0);
        check("t5b_ireq_cycles", 32'(ireq_cycles), 32'(TMO));

        // 6: reset asserted during a data wait
        do_reset();
        fill(I_NOP); imem_arr[1] = I_LW; alu_out = 32'h100; dmem_delay = 10;
        exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4);
        exp_dmem.push_back('{addr: 32'h100, we: 1'b0, size: 3'b010});
        rst_n = 1'b1;
        run(9);
        check("t6_pre_dreq", 32'(dmem_req), 32'd1);
        check("t6_pre_pc", pc, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_dreq_async", 32'(dmem_req), 32'd0);
        check("t6_pc_async", pc, 32'h0);
        check("t6_rf_we", 32'(rf_we), 32'd0);
        exp_dmem.delete();
        tick();
        exp_fetch.push_back(32'h0);
        rst_n = 1'b1;
        run(1);
        check("t6_refetch", 32'(imem_req), 32'd1);
        check("t6_halt", 32'(halt), 32'd0);
        drained("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
